// File: rtl/dvi_tmds_encode.sv
// DVI/HDMI TMDS encoder for one pixel clock domain.
// Takes registered VGA timing plus RGB565 and produces three 10-bit TMDS
// symbols per pixel. Three register stages: expand+popcount,
// transition minimisation, then DC balance / control token select.
// Symbol bit 0 is the first bit on the wire.
module dvi_tmds_encode #(
    parameter int EXPAND_REPL = 1
) (
    input  logic        pix_clk,
    input  logic        pix_rstn,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_de,
    input  logic [15:0] in_rgb,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_de
);

    // Control-period tokens indexed by {C1,C0}
    localparam logic [9:0] TOKEN_00 = 10'h354;
    localparam logic [9:0] TOKEN_01 = 10'h0AB;
    localparam logic [9:0] TOKEN_10 = 10'h154;
    localparam logic [9:0] TOKEN_11 = 10'h2AB;

    // RGB565 -> RGB888 expansion; replication keeps full-scale white at 8'hFF
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;

    generate
        if (EXPAND_REPL != 0) begin : gen_repl
            assign r8 = {in_rgb[15:11], in_rgb[15:13]};
            assign g8 = {in_rgb[10:5],  in_rgb[10:9]};
            assign b8 = {in_rgb[4:0],   in_rgb[4:2]};
        end else begin : gen_zero
            assign r8 = {in_rgb[15:11], 3'b000};
            assign g8 = {in_rgb[10:5],  2'b00};
            assign b8 = {in_rgb[4:0],   3'b000};
        end
    endgenerate

    // Index 0 = blue (ch0), 1 = green (ch1), 2 = red (ch2)
    logic [2:0][7:0] pix_exp;
    assign pix_exp = {r8, g8, b8};

    // Timing signals ride alongside the data through all three stages
    logic de_s1_reg, hs_s1_reg, vs_s1_reg;
    logic de_s2_reg, hs_s2_reg, vs_s2_reg;
    logic out_de_reg, out_hs_reg, out_vs_reg;

    // Delay line for de/hsync/vsync, cleared on reset
    always_ff @(posedge pix_clk) begin
        if (!pix_rstn) begin
            de_s1_reg  <= 1'b0;
            hs_s1_reg  <= 1'b0;
            vs_s1_reg  <= 1'b0;
            de_s2_reg  <= 1'b0;
            hs_s2_reg  <= 1'b0;
            vs_s2_reg  <= 1'b0;
            out_de_reg <= 1'b0;
            out_hs_reg <= 1'b0;
            out_vs_reg <= 1'b0;
        end else begin
            de_s1_reg  <= in_de;
            hs_s1_reg  <= in_hsync;
            vs_s1_reg  <= in_vsync;
            de_s2_reg  <= de_s1_reg;
            hs_s2_reg  <= hs_s1_reg;
            vs_s2_reg  <= vs_s1_reg;
            out_de_reg <= de_s2_reg;
            out_hs_reg <= hs_s2_reg;
            out_vs_reg <= vs_s2_reg;
        end
    end

    logic [2:0][9:0] sym_all;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_ch
            logic [3:0] n1_next;
            logic [7:0] d_s1_reg;
            logic [3:0] n1_s1_reg;
            logic       use_xnor;
            logic [8:0] qm_next;
            logic [3:0] qm_n1_next;
            logic [8:0] qm_s2_reg;
            logic [3:0] qm_n1_s2_reg;
            logic [3:0] qm_n0_s2_reg;
            logic [1:0] ctrl;
            logic [5:0] diff;
            logic [5:0] cnt_next;
            logic [5:0] cnt_reg;
            logic [9:0] sym_next;
            logic [9:0] sym_reg;

            // Population count of the expanded 8-bit component
            always_comb begin
                n1_next = 4'd0;
                for (int i = 0; i < 8; i++) begin
                    n1_next = n1_next + {3'b000, pix_exp[gi][i]};
                end
            end

            // Stage 1: expanded component and its ones count
            always_ff @(posedge pix_clk) begin
                if (!pix_rstn) begin
                    d_s1_reg  <= 8'd0;
                    n1_s1_reg <= 4'd0;
                end else begin
                    d_s1_reg  <= pix_exp[gi];
                    n1_s1_reg <= n1_next;
                end
            end

            // Transition-minimising XOR/XNOR chain and ones count of its result
            always_comb begin
                use_xnor   = (n1_s1_reg > 4'd4) || ((n1_s1_reg == 4'd4) && !d_s1_reg[0]);
                qm_next    = 9'd0;
                qm_next[0] = d_s1_reg[0];
                for (int i = 1; i < 8; i++) begin
                    qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ d_s1_reg[i])
                                          :  (qm_next[i-1] ^ d_s1_reg[i]);
                end
                qm_next[8] = ~use_xnor;
                qm_n1_next = 4'd0;
                for (int i = 0; i < 8; i++) begin
                    qm_n1_next = qm_n1_next + {3'b000, qm_next[i]};
                end
            end

            // Stage 2: q_m word with ones/zeros counts of its low byte
            always_ff @(posedge pix_clk) begin
                if (!pix_rstn) begin
                    qm_s2_reg    <= 9'd0;
                    qm_n1_s2_reg <= 4'd0;
                    qm_n0_s2_reg <= 4'd0;
                end else begin
                    qm_s2_reg    <= qm_next;
                    qm_n1_s2_reg <= qm_n1_next;
                    qm_n0_s2_reg <= 4'd8 - qm_n1_next;
                end
            end

            // Only the blue channel carries hsync/vsync during blanking
            assign ctrl = (gi == 0) ? {vs_s2_reg, hs_s2_reg} : 2'b00;

            // DC balance: choose inversion from running disparity, or emit a token
            always_comb begin
                diff     = {2'b00, qm_n1_s2_reg} - {2'b00, qm_n0_s2_reg};
                sym_next = TOKEN_00;
                cnt_next = cnt_reg;
                if (!de_s2_reg) begin
                    cnt_next = 6'd0;
                    case (ctrl)
                        2'b01:   sym_next = TOKEN_01;
                        2'b10:   sym_next = TOKEN_10;
                        2'b11:   sym_next = TOKEN_11;
                        default: sym_next = TOKEN_00;
                    endcase
                end else if ((cnt_reg == 6'd0) || (qm_n1_s2_reg == qm_n0_s2_reg)) begin
                    sym_next = {~qm_s2_reg[8], qm_s2_reg[8],
                                qm_s2_reg[8] ? qm_s2_reg[7:0] : ~qm_s2_reg[7:0]};
                    cnt_next = qm_s2_reg[8] ? (cnt_reg + diff) : (cnt_reg - diff);
                end else if ((!cnt_reg[5] && (qm_n1_s2_reg > qm_n0_s2_reg)) ||
                             ( cnt_reg[5] && (qm_n0_s2_reg > qm_n1_s2_reg))) begin
                    sym_next = {1'b1, qm_s2_reg[8], ~qm_s2_reg[7:0]};
                    cnt_next = cnt_reg + {4'b0000, qm_s2_reg[8], 1'b0} - diff;
                end else begin
                    sym_next = {1'b0, qm_s2_reg[8], qm_s2_reg[7:0]};
                    cnt_next = cnt_reg - (qm_s2_reg[8] ? 6'd0 : 6'd2) + diff;
                end
            end

            // Stage 3: output symbol and running disparity
            always_ff @(posedge pix_clk) begin
                if (!pix_rstn) begin
                    sym_reg <= TOKEN_00;
                    cnt_reg <= 6'd0;
                end else begin
                    sym_reg <= sym_next;
                    cnt_reg <= cnt_next;
                end
            end

            assign sym_all[gi] = sym_reg;
        end
    endgenerate

    assign tmds_ch0  = sym_all[0];
    assign tmds_ch1  = sym_all[1];
    assign tmds_ch2  = sym_all[2];
    assign out_hsync = out_hs_reg;
    assign out_vsync = out_vs_reg;
    assign out_de    = out_de_reg;

endmodule

// File: tb/tb_dvi_tmds_encode.sv
// Bench for dvi_tmds_encode: two instances (replicating and zero-fill
// expansion) driven by the same stimulus, checked every cycle against a
// reference model, plus hand-computed expected symbols.
module tb_dvi_tmds_encode;

    logic        pix_clk = 1'b0;
    logic        pix_rstn = 1'b0;
    logic        in_hsync = 1'b0;
    logic        in_vsync = 1'b0;
    logic        in_de = 1'b0;
    logic [15:0] in_rgb = 16'h0000;

    logic [9:0] ch0_a, ch1_a, ch2_a, ch0_b, ch1_b, ch2_b;
    logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    always #5 pix_clk = ~pix_clk;

    dvi_tmds_encode #(.EXPAND_REPL(1)) u_dut_repl (
        .pix_clk(pix_clk), .pix_rstn(pix_rstn),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de), .in_rgb(in_rgb),
        .tmds_ch0(ch0_a), .tmds_ch1(ch1_a), .tmds_ch2(ch2_a),
        .out_hsync(hs_a), .out_vsync(vs_a), .out_de(de_a)
    );

    dvi_tmds_encode #(.EXPAND_REPL(0)) u_dut_zero (
        .pix_clk(pix_clk), .pix_rstn(pix_rstn),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de), .in_rgb(in_rgb),
        .tmds_ch0(ch0_b), .tmds_ch1(ch1_b), .tmds_ch2(ch2_b),
        .out_hsync(hs_b), .out_vsync(vs_b), .out_de(de_b)
    );

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] rgb;
    } rec_t;

    rec_t       hist [3];
    int         cnt_m [2][3];
    logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic       started = 1'b0;
    // {ch2, ch1, ch0, hsync, vsync, de}
    logic [32:0] exp_a, exp_b;

    // Component of a pixel as 8 bits: ch 0 = blue, 1 = green, 2 = red
    function automatic logic [7:0] expand(input logic [15:0] rgb, input int ch, input int repl);
        int v;
        int w;
        case (ch)
            0:       begin v = int'(rgb[4:0]);   w = 5; end
            1:       begin v = int'(rgb[10:5]);  w = 6; end
            default: begin v = int'(rgb[15:11]); w = 5; end
        endcase
        if (repl != 0) return 8'((v << (8 - w)) | (v >> (2 * w - 8)));
        return 8'(v << (8 - w));
    endfunction

    // Data symbol; running disparity tracked as ones-minus-zeros of all sent bits
    function automatic logic [9:0] encode_data(input logic [7:0] d, input int inst, input int ch);
        int         ones;
        int         bal;
        logic       flip;
        logic       inv;
        logic [8:0] qm;
        logic [9:0] s;
        ones = $countones(d);
        flip = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ flip;
        qm[8] = !flip;
        bal = 2 * $countones(qm[7:0]) - 8;
        if (cnt_m[inst][ch] == 0 || bal == 0) inv = !qm[8];
        else inv = ((cnt_m[inst][ch] > 0) == (bal > 0));
        s = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
        cnt_m[inst][ch] = cnt_m[inst][ch] + 2 * $countones(s) - 10;
        return s;
    endfunction

    function automatic logic [32:0] model(input rec_t r, input int inst);
        logic [9:0] s [3];
        if (!r.de) begin
            for (int c = 0; c < 3; c++) cnt_m[inst][c] = 0;
            s[0] = tok[{r.vs, r.hs}];
            s[1] = 10'h354;
            s[2] = 10'h354;
        end else begin
            for (int c = 0; c < 3; c++) s[c] = encode_data(expand(r.rgb, c, (inst == 0) ? 1 : 0), inst, c);
        end
        return {s[2], s[1], s[0], r.hs, r.vs, r.de};
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    // Per-cycle comparison of both instances against the model
    always @(posedge pix_clk) begin
        rec_t        cur;
        logic        rs;
        logic [32:0] act;
        logic [23:0] dec;
        logic [23:0] want;
        cur.de = in_de;
        cur.hs = in_hsync;
        cur.vs = in_vsync;
        cur.rgb = in_rgb;
        rs = pix_rstn;
        #1;
        cycle++;
        if (!rs) begin
            for (int k = 0; k < 3; k++) begin
                hist[k].de = 1'b0; hist[k].hs = 1'b0; hist[k].vs = 1'b0; hist[k].rgb = 16'h0;
            end
            for (int k = 0; k < 3; k++) begin cnt_m[0][k] = 0; cnt_m[1][k] = 0; end
            exp_a = {10'h354, 10'h354, 10'h354, 3'b000};
            exp_b = exp_a;
            started = 1'b1;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = cur;
            exp_a = model(hist[2], 0);
            exp_b = model(hist[2], 1);
        end
        if (started) begin
            act = {ch2_a, ch1_a, ch0_a, hs_a, vs_a, de_a};
            vectors++;
            if (act !== exp_a) begin
                miscompares++;
                $display("FAIL cycle %0d repl outputs: got %h required %h", cycle, act, exp_a);
            end
            act = {ch2_b, ch1_b, ch0_b, hs_b, vs_b, de_b};
            vectors++;
            if (act !== exp_b) begin
                miscompares++;
                $display("FAIL cycle %0d zero outputs: got %h required %h", cycle, act, exp_b);
            end
            if (rs && hist[2].de) begin
                dec  = {decode(ch2_a), decode(ch1_a), decode(ch0_a)};
                want = {expand(hist[2].rgb, 2, 1), expand(hist[2].rgb, 1, 1), expand(hist[2].rgb, 0, 1)};
                vectors++;
                if (dec !== want) begin
                    miscompares++;
                    $display("FAIL cycle %0d decode: got %h required %h", cycle, dec, want);
                end
            end
        end
    end

    task automatic drive(input logic rstn, input logic de, input logic hs, input logic vs,
                         input logic [15:0] rgb);
        @(negedge pix_clk);
        pix_rstn = rstn;
        in_de    = de;
        in_hsync = hs;
        in_vsync = vs;
        in_rgb   = rgb;
    endtask

    task automatic wait_out();
        @(posedge pix_clk);
        #2;
    endtask

    task automatic settle();
        repeat (3) @(posedge pix_clk);
        #2;
    endtask

    task automatic check_lit(input string name, input logic [9:0] got, input logic [9:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        // Reset, then idle blanking
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        wait_out();
        check_lit("t1 rst ch0", ch0_a, 10'h354);
        check_lit("t1 rst ch1", ch1_a, 10'h354);
        check_lit("t1 rst ch2", ch2_a, 10'h354);
        check_lit("t1 rst de", {9'd0, de_a}, 10'h000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
            wait_out();
            check_lit("t1 idle ch0", ch0_a, 10'h354);
        end

        // Control tokens
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        settle();
        check_lit("t2 hs ch0", ch0_a, 10'h0AB);
        check_lit("t2 hs ch1", ch1_a, 10'h354);
        check_lit("t2 hs ch2", ch2_a, 10'h354);
        check_lit("t2 hs out", {9'd0, hs_a}, 10'h001);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        settle();
        check_lit("t2 hsvs ch0", ch0_a, 10'h2AB);
        check_lit("t2 hsvs model", exp_a[12:3], 10'h2AB);

        // DC balance over three black pixels
        blank(3);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        wait_out();
        check_lit("t3 px0 ch0", ch0_a, 10'h100);
        check_lit("t3 px0 model", exp_a[12:3], 10'h100);
        wait_out();
        check_lit("t3 px1 ch0", ch0_a, 10'h3FF);
        check_lit("t3 px1 model", exp_a[12:3], 10'h3FF);
        wait_out();
        check_lit("t3 px2 ch0", ch0_a, 10'h100);

        // Expansion
        blank(3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'hF800);
        settle();
        check_lit("t4 red ch2", ch2_a, 10'h200);
        check_lit("t4 red ch1", ch1_a, 10'h100);
        check_lit("t4 red ch0", ch0_a, 10'h100);
        blank(3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0821);
        settle();
        check_lit("t4 zero ch2", ch2_b, 10'h1F8);
        check_lit("t4 zero ch1", ch1_b, 10'h1FC);
        check_lit("t4 zero ch0", ch0_b, 10'h1F8);
        check_lit("t4 zero model", exp_b[32:23], 10'h1F8);

        // Reset in the middle of active video
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'($urandom));
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'($urandom));
        wait_out();
        check_lit("t5 rst ch0", ch0_a, 10'h354);
        check_lit("t5 rst ch1", ch1_a, 10'h354);
        check_lit("t5 rst ch2", ch2_a, 10'h354);
        check_lit("t5 rst de", {9'd0, de_a}, 10'h000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'hF800);
        settle();
        check_lit("t5 first ch2", ch2_a, 10'h200);
        check_lit("t5 first ch0", ch0_a, 10'h100);

        // Random soak, including de toggling and occasional resets
        for (int i = 0; i < 10000; i++) begin
            logic r;
            logic d;
            r = ($urandom_range(0, 499) != 0);
            if (i >= 4000 && i < 4200) d = i[0];
            else d = ($urandom_range(0, 3) != 0);
            drive(r, d, 1'($urandom), 1'($urandom), 16'($urandom));
        end
        blank(4);
        wait_out();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
